key_store: RTL and testbench

Parametrised round-key storage for the cipher datapath: a DEPTH-entry, DATA_W-bit register array that the key-expansion logic fills sequentially and the round logic reads by round index. It extends the fixed 15×128 store with a streaming load handshake, a fill-status flag and a forward/reverse read mode for decryption. It also adds a hardware clear sweep and out-of-range read detection. It sits between the key-expansion unit (writer) and the round controller (reader).

---
 rtl/key_store.sv | 144 ++++++++++++++
 tb/tb_key_store.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_store.sv
// Round-key register array: sequential streaming load, clear sweep, and forward/reverse indexed reads.
// Latency: registered reads (1 cycle); one word accepted per cycle while loading; a clear takes DEPTH cycles.
module key_store #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 15,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              full,
    input  logic              clr,
    output logic              busy,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_rev,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err
);

    typedef enum logic [1:0] {S_EMPTY, S_LOADING, S_FULL, S_CLEARING} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   cptr_q, cptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                rd_in_range;
    logic [ADDR_W-1:0]   rd_idx;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                rd_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            wptr_q  <= '0;
            cptr_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            cptr_q  <= cptr_d;
        end
    end

    // clr outranks load_start, and load_start outranks a same-cycle write.
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        cptr_d    = cptr_q;
        mem_we    = 1'b0;
        mem_waddr = wptr_q;
        mem_wdata = wr_data;
        if (clr) begin
            state_d = S_CLEARING;
            cptr_d  = '0;
        end else begin
            case (state_q)
                S_EMPTY, S_FULL: begin
                    if (load_start) begin
                        state_d = S_LOADING;
                        wptr_d  = '0;
                    end
                end
                S_LOADING: begin
                    if (load_start) begin
                        wptr_d = '0;
                    end else if (wr_valid) begin
                        mem_we = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                        if (wptr_q == LAST) begin
                            state_d = S_FULL;
                            wptr_d  = '0;
                        end
                    end
                end
                S_CLEARING: begin
                    mem_we    = 1'b1;
                    mem_waddr = cptr_q;
                    mem_wdata = '0;
                    cptr_d    = cptr_q + 1'b1;
                    if (cptr_q == LAST) begin
                        state_d = S_EMPTY;
                        cptr_d  = '0;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        wr_ready = (state_q == S_LOADING);
        full     = (state_q == S_FULL);
        busy     = (state_q == S_CLEARING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_in_range = 32'(rd_addr) < 32'(DEPTH);
    assign rd_idx      = rd_rev ? (LAST - rd_addr) : rd_addr;

    // Reads sample mem_q before this edge's write, so a colliding read sees the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            rd_err_q   <= rd_en && !rd_in_range;
            if (rd_en) begin
                if (rd_in_range) begin
                    rd_data_q <= mem_q[rd_idx];
                end else begin
                    rd_data_q <= '0;
                end
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_key_store.sv
// Directed bench for key_store: default 128x15 instance plus a 64x11 instance for scaling.
module tb_key_store;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         load_start, wr_valid, wr_ready, full, clr, busy;
    logic [127:0] wr_data, rd_data;
    logic         rd_en, rd_rev, rd_valid, rd_err;
    logic [3:0]   rd_addr;

    logic         b_load_start, b_wr_valid, b_wr_ready, b_full, b_clr, b_busy;
    logic [63:0]  b_wr_data, b_rd_data;
    logic         b_rd_en, b_rd_rev, b_rd_valid, b_rd_err;
    logic [3:0]   b_rd_addr;

    int total = 0;
    int bad   = 0;

    key_store dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .full(full), .clr(clr), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_rev(rd_rev),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err)
    );

    key_store #(.DATA_W(64), .DEPTH(11), .ADDR_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .load_start(b_load_start), .wr_valid(b_wr_valid), .wr_data(b_wr_data),
        .wr_ready(b_wr_ready), .full(b_full), .clr(b_clr), .busy(b_busy),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_rev(b_rd_rev),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_err(b_rd_err)
    );

    function automatic logic [127:0] w1(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {120'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5, b};
    endfunction

    function automatic logic [63:0] w2(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {56'h3C3C_3C3C_3C3C_3C, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_start = 0; wr_valid = 0; wr_data = '0; clr = 0; rd_en = 0; rd_addr = '0; rd_rev = 0;
        b_load_start = 0; b_wr_valid = 0; b_wr_data = '0; b_clr = 0; b_rd_en = 0; b_rd_addr = '0; b_rd_rev = 0;
        step();
        step();
        total++;
        if ({wr_ready, full, busy, rd_valid, rd_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000", {wr_ready, full, busy, rd_valid, rd_err});
        end
        total++;
        if (rd_data !== '0) begin
            bad++;
            $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
        total++;
        if ({b_wr_ready, b_full, b_busy, b_rd_valid, b_rd_err} !== 5'b0 || b_rd_data !== '0) begin
            bad++;
            $display("FAIL reset_dut2: flags %b data %h want all 0",
                     {b_wr_ready, b_full, b_busy, b_rd_valid, b_rd_err}, b_rd_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load();
        load_start = 1;
        step();
        load_start = 0;
        total++;
        if (wr_ready !== 1'b1 || full !== 1'b0) begin
            bad++;
            $display("FAIL load_enter: wr_ready=%b full=%b want 1 0", wr_ready, full);
        end
        for (int i = 0; i < 15; i++) begin
            wr_valid = 1;
            wr_data  = w1(i);
            step();
            if (i == 13) begin
                total++;
                if (full !== 1'b0 || wr_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL load_14th: full=%b wr_ready=%b want 0 1", full, wr_ready);
                end
            end
        end
        wr_valid = 0;
        total++;
        if (full !== 1'b1 || wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_full: full=%b wr_ready=%b want 1 0", full, wr_ready);
        end
        for (int a = 0; a < 15; a++) begin
            rd_en = 1; rd_addr = 4'(a); rd_rev = 0;
            step();
            total++;
            if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_data !== w1(a)) begin
                bad++;
                $display("FAIL read_fwd[%0d]: v=%b e=%b d=%h want 1 0 %h", a, rd_valid, rd_err, rd_data, w1(a));
            end
        end
        rd_en = 0;
        step();
        total++;
        if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_data !== w1(14)) begin
            bad++;
            $display("FAIL read_hold: v=%b e=%b d=%h want 0 0 %h", rd_valid, rd_err, rd_data, w1(14));
        end
    endtask

    task automatic test_reverse();
        for (int a = 0; a < 15; a++) begin
            rd_en = 1; rd_addr = 4'(a); rd_rev = 1;
            step();
            total++;
            if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_data !== w1(14 - a)) begin
                bad++;
                $display("FAIL read_rev[%0d]: v=%b e=%b d=%h want 1 0 %h", a, rd_valid, rd_err, rd_data, w1(14 - a));
            end
        end
        rd_en = 0; rd_rev = 0;
        step();
    endtask

    task automatic test_oob();
        rd_en = 1; rd_addr = 4'd15; rd_rev = 0;
        step();
        total++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_data !== '0) begin
            bad++;
            $display("FAIL oob_fwd: v=%b e=%b d=%h want 1 1 0", rd_valid, rd_err, rd_data);
        end
        rd_rev = 1;
        step();
        total++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_data !== '0) begin
            bad++;
            $display("FAIL oob_rev: v=%b e=%b d=%h want 1 1 0", rd_valid, rd_err, rd_data);
        end
        rd_en = 0; rd_rev = 0;
        step();
        total++;
        if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin
            bad++;
            $display("FAIL oob_idle: v=%b e=%b want 0 0", rd_valid, rd_err);
        end
    endtask

    task automatic test_clear_mid_load();
        int n;
        load_start = 1;
        step();
        load_start = 0;
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1; wr_data = w1(8'h40 + i);
            step();
        end
        clr = 1; wr_data = w1(8'h4F);
        step();
        clr = 0;
        total++;
        if (busy !== 1'b1 || full !== 1'b0 || wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL clr_enter: busy=%b full=%b wr_ready=%b want 1 0 0", busy, full, wr_ready);
        end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            load_start = (n == 3);
            step();
        end
        load_start = 0; wr_valid = 0;
        total++;
        if (n != 15) begin
            bad++;
            $display("FAIL clr_busy_len: got %0d cycles want 15", n);
        end
        total++;
        if (busy !== 1'b0 || wr_ready !== 1'b0 || full !== 1'b0) begin
            bad++;
            $display("FAIL clr_empty: busy=%b wr_ready=%b full=%b want 0 0 0", busy, wr_ready, full);
        end
        for (int a = 0; a < 15; a++) begin
            rd_en = 1; rd_addr = 4'(a);
            step();
            total++;
            if (rd_data !== '0 || rd_valid !== 1'b1) begin
                bad++;
                $display("FAIL clr_read[%0d]: v=%b d=%h want 1 0", a, rd_valid, rd_data);
            end
        end
        rd_en = 0;
        step();
    endtask

    task automatic test_same_cycle();
        load_start = 1;
        step();
        load_start = 0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_data = w1(8'h50 + i);
            step();
        end
        wr_data = w1(8'h53); rd_en = 1; rd_addr = 4'd3; rd_rev = 0;
        step();
        total++;
        if (rd_data !== '0 || rd_valid !== 1'b1) begin
            bad++;
            $display("FAIL rw_collide_old: v=%b d=%h want 1 0", rd_valid, rd_data);
        end
        wr_valid = 0;
        step();
        total++;
        if (rd_data !== w1(8'h53)) begin
            bad++;
            $display("FAIL rw_collide_new: got %h want %h", rd_data, w1(8'h53));
        end
        rd_en = 0; load_start = 1; wr_valid = 1; wr_data = w1(8'h77);
        step();
        load_start = 0; wr_data = w1(8'h60);
        step();
        wr_valid = 0; rd_en = 1; rd_addr = 4'd0;
        step();
        total++;
        if (rd_data !== w1(8'h60)) begin
            bad++;
            $display("FAIL restart_wptr0: entry0 got %h want %h", rd_data, w1(8'h60));
        end
        rd_addr = 4'd4;
        step();
        total++;
        if (rd_data !== '0) begin
            bad++;
            $display("FAIL restart_nowrite: entry4 got %h want 0", rd_data);
        end
        rd_addr = 4'd1;
        step();
        total++;
        if (rd_data !== w1(8'h51)) begin
            bad++;
            $display("FAIL restart_keep: entry1 got %h want %h", rd_data, w1(8'h51));
        end
        rd_en = 0;
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL restart_loading: wr_ready=%b want 1", wr_ready);
        end
    endtask

    task automatic test_reset_during_clear();
        load_start = 1;
        step();
        load_start = 0;
        for (int i = 0; i < 15; i++) begin
            wr_valid = 1; wr_data = w1(8'h80 + i);
            step();
        end
        wr_valid = 0;
        clr = 1; rd_en = 1; rd_addr = 4'd9; rd_rev = 0;
        step();
        clr = 0; rd_en = 0;
        total++;
        if (busy !== 1'b1 || rd_data !== w1(8'h89)) begin
            bad++;
            $display("FAIL pre_reset: busy=%b d=%h want 1 %h", busy, rd_data, w1(8'h89));
        end
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        total++;
        if ({wr_ready, full, busy, rd_valid, rd_err} !== 5'b0 || rd_data !== '0) begin
            bad++;
            $display("FAIL reset_async: flags %b d=%h want 00000 0", {wr_ready, full, busy, rd_valid, rd_err}, rd_data);
        end
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (busy !== 1'b0 || wr_ready !== 1'b0 || full !== 1'b0) begin
            bad++;
            $display("FAIL reset_empty: busy=%b wr_ready=%b full=%b want 0 0 0", busy, wr_ready, full);
        end
        for (int a = 0; a < 15; a++) begin
            rd_en = 1; rd_addr = 4'(a);
            step();
            total++;
            if (rd_data !== '0) begin
                bad++;
                $display("FAIL reset_read[%0d]: got %h want 0", a, rd_data);
            end
        end
        rd_en = 0;
        step();
    endtask

    task automatic test_scaled();
        b_load_start = 1;
        step();
        b_load_start = 0;
        for (int i = 0; i < 11; i++) begin
            b_wr_valid = 1; b_wr_data = w2(i);
            step();
            if (i == 9) begin
                total++;
                if (b_full !== 1'b0 || b_wr_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL s_load_10th: full=%b wr_ready=%b want 0 1", b_full, b_wr_ready);
                end
            end
        end
        b_wr_valid = 0;
        total++;
        if (b_full !== 1'b1 || b_wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL s_load_full: full=%b wr_ready=%b want 1 0", b_full, b_wr_ready);
        end
        for (int a = 0; a < 11; a++) begin
            b_rd_en = 1; b_rd_addr = 4'(a); b_rd_rev = 0;
            step();
            total++;
            if (b_rd_valid !== 1'b1 || b_rd_data !== w2(a)) begin
                bad++;
                $display("FAIL s_read_fwd[%0d]: v=%b d=%h want 1 %h", a, b_rd_valid, b_rd_data, w2(a));
            end
        end
        for (int a = 0; a < 11; a++) begin
            b_rd_en = 1; b_rd_addr = 4'(a); b_rd_rev = 1;
            step();
            total++;
            if (b_rd_valid !== 1'b1 || b_rd_data !== w2(10 - a)) begin
                bad++;
                $display("FAIL s_read_rev[%0d]: v=%b d=%h want 1 %h", a, b_rd_valid, b_rd_data, w2(10 - a));
            end
        end
        b_rd_addr = 4'd11; b_rd_rev = 0;
        step();
        total++;
        if (b_rd_valid !== 1'b1 || b_rd_err !== 1'b1 || b_rd_data !== '0) begin
            bad++;
            $display("FAIL s_oob: v=%b e=%b d=%h want 1 1 0", b_rd_valid, b_rd_err, b_rd_data);
        end
        b_rd_en = 0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load();
        test_reverse();
        test_oob();
        test_clear_mid_load();
        test_same_cycle();
        test_reset_during_clear();
        test_scaled();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
